// File: rtl/ex_muldiv.sv
// ----------------------------------------------------------------------------
// ex_muldiv
// Iterative multiply/divide unit that sits inside the execute stage.
// Takes mult/multu/div/divu from the decode-to-execute bus and asks the
// pipeline to stall while it iterates. It then presents the 64-bit hi/lo
// result for one cycle with a done pulse.
//
// Ports
//   clk       clock
//   rst       synchronous, active-high reset
//   in_valid  EX holds a valid instruction this cycle
//   op        {mult, multu, div, divu}, one-hot or zero (zero = no muldiv op)
//   src_a     rs operand (already forwarded)
//   src_b     rt operand (already forwarded)
//   cancel    flush; aborts any operation in progress
//   stallreq  combinational request to stall IF/ID/EX
//   done      one-cycle pulse; hi/lo are valid while it is high
//   hi        product[63:32] or remainder
//   lo        product[31:0] or quotient
// ----------------------------------------------------------------------------
module ex_muldiv #(
    parameter int                DATA_W  = 32,
    parameter logic [DATA_W-1:0] DIV0_LO = 32'hFFFF_FFFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    input  logic              cancel,
    output logic              stallreq,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam logic [5:0] LAST = 6'(DATA_W - 1);

    state_t                state;
    logic [5:0]            count;
    logic [2*DATA_W-1:0]   acc;     // product accumulator, or {rem, quot}
    logic [2*DATA_W-1:0]   mcand;   // multiplicand, shifted left each MUL step
    logic [DATA_W-1:0]     mplier;  // multiplier in MUL, fixed divisor in DIV
    logic                  sign_a;
    logic                  sign_b;

    logic                  start;
    logic                  signed_op;
    logic                  is_mul;
    logic [DATA_W-1:0]     abs_a;
    logic [DATA_W-1:0]     abs_b;

    logic [2*DATA_W-1:0]   mul_sum;
    logic [2*DATA_W-1:0]   mul_final;

    logic [2*DATA_W:0]     div_shift;
    logic [DATA_W+1:0]     div_diff;
    logic [2*DATA_W-1:0]   div_next;
    logic [DATA_W-1:0]     div_hi;
    logic [DATA_W-1:0]     div_lo;

    // Start decode and operand magnitudes. Unsigned ops skip the abs step.
    // The abs of 0x80000000 stays 0x80000000, which is correct when read as
    // unsigned.
    always_comb begin
        start     = in_valid & (|op) & ~cancel;
        signed_op = op[3] | op[1];
        is_mul    = op[3] | op[2];
        abs_a     = (signed_op & src_a[DATA_W-1]) ? -src_a : src_a;
        abs_b     = (signed_op & src_b[DATA_W-1]) ? -src_b : src_b;
    end

    // One shift-add step. The sign flags are zero for unsigned ops, so the
    // same negate path covers both flavours.
    always_comb begin
        mul_sum   = acc + (mplier[0] ? mcand : '0);
        mul_final = (sign_a ^ sign_b) ? -mul_sum : mul_sum;
    end

    // One restoring-division step. The shifted remainder can need 33 bits,
    // so the subtract is done one bit wider still, to read the borrow.
    always_comb begin
        div_shift = {acc, 1'b0};
        div_diff  = {1'b0, div_shift[2*DATA_W:DATA_W]} - {2'b00, mplier};
        if (!div_diff[DATA_W+1]) begin
            div_next = {div_diff[DATA_W-1:0], div_shift[DATA_W-1:1], 1'b1};
        end else begin
            div_next = div_shift[2*DATA_W-1:0];
        end
        div_lo = (sign_a ^ sign_b) ? -div_next[DATA_W-1:0] : div_next[DATA_W-1:0];
        div_hi = sign_a ? -div_next[2*DATA_W-1:DATA_W] : div_next[2*DATA_W-1:DATA_W];
    end

    // The issuing cycle stalls too, so the instruction stays in EX until DONE.
    assign stallreq = ((state == IDLE) & start) | (state == MUL) | (state == DIV);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
        end else begin
            done <= 1'b0;
            if (cancel) begin
                state <= IDLE;
                count <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            sign_a <= signed_op & src_a[DATA_W-1];
                            sign_b <= signed_op & src_b[DATA_W-1];
                            count  <= '0;
                            mplier <= abs_b;
                            if (is_mul) begin
                                acc   <= '0;
                                mcand <= {{DATA_W{1'b0}}, abs_a};
                                state <= MUL;
                            end else if (src_b != '0) begin
                                acc   <= {{DATA_W{1'b0}}, abs_a};
                                state <= DIV;
                            end else begin
                                hi    <= src_a;
                                lo    <= DIV0_LO;
                                done  <= 1'b1;
                                state <= DONE;
                            end
                        end
                    end
                    MUL: begin
                        acc    <= mul_sum;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        count  <= count + 6'd1;
                        if (count == LAST) begin
                            hi    <= mul_final[2*DATA_W-1:DATA_W];
                            lo    <= mul_final[DATA_W-1:0];
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DIV: begin
                        acc   <= div_next;
                        count <= count + 6'd1;
                        if (count == LAST) begin
                            hi    <= div_hi;
                            lo    <= div_lo;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                    DONE: begin
                        // The stalled instruction is still presented here,
                        // so it must not restart.
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// ----------------------------------------------------------------------------
// tb_ex_muldiv
// Directed testbench for ex_muldiv. A table of hand-computed vectors runs
// back to back. Each vector checks hi/lo, the done cycle and the stall window.
// Hand-written sequences then cover held issue, cancel and reset aborts.
// ----------------------------------------------------------------------------
module tb_ex_muldiv;

    localparam logic [3:0] OP_MULT  = 4'b1000;
    localparam logic [3:0] OP_MULTU = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          exp_cyc;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    always #5 clk = ~clk;

    ex_muldiv #(.DATA_W(32), .DIV0_LO(32'hFFFF_FFFF)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .stallreq (stallreq),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    // One comparison; every check in the bench goes through here.
    task automatic checkOutput(input string what, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, actual, expected);
        end
    endtask

    // Presents one vector starting in an IDLE cycle (called just after a
    // posedge). It holds the instruction until done, as a stalled pipeline
    // would. It returns just after the posedge that leaves DONE.
    task automatic applyStimulus(input vec_t v, input int idx);
        int done_cyc;
        int stall_bad;
        done_cyc  = -1;
        stall_bad = 0;
        in_valid  = 1'b1;
        op        = v.op;
        src_a     = v.a;
        src_b     = v.b;
        cancel    = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (stallreq !== (cyc < v.exp_cyc)) stall_bad++;
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput($sformatf("vec%0d done_cycle", idx), 32'(done_cyc), 32'(v.exp_cyc));
        if (done_cyc < 0) begin
            rst      = 1'b1;
            in_valid = 1'b0;
            op       = 4'b0000;
            @(posedge clk);
            #1;
            rst = 1'b0;
        end else begin
            checkOutput($sformatf("vec%0d hi", idx), hi, v.exp_hi);
            checkOutput($sformatf("vec%0d lo", idx), lo, v.exp_lo);
            checkOutput($sformatf("vec%0d stall_window_errors", idx), 32'(stall_bad), 32'd0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dones;
        int done_at;
        logic stall33;
        logic stall34;

        vecs[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 33};
        vecs[1]  = '{OP_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 33};
        vecs[2]  = '{OP_DIVU,  32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 33};
        vecs[3]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
        vecs[4]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
        vecs[5]  = '{OP_DIV,   32'h0000_1234, 32'h0,         32'h0000_1234, 32'hFFFF_FFFF, 1};
        vecs[6]  = '{OP_DIVU,  32'd5,         32'h0,         32'h0000_0005, 32'hFFFF_FFFF, 1};
        vecs[7]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 33};
        vecs[8]  = '{OP_MULTU, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 33};
        vecs[9]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
        vecs[10] = '{OP_DIVU,  32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 32'h0000_0001, 33};
        vecs[11] = '{OP_MULT,  32'h0,         32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 33};
        vecs[12] = '{OP_DIV,   32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h0000_0002, 33};

        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'b0000;
        src_a    = '0;
        src_b    = '0;
        cancel   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset hi", hi, 32'h0);
        checkOutput("reset lo", lo, 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset stallreq", 32'(stallreq), 32'h0);
        @(posedge clk);
        #1;

        $display("[TB] running %0d table vectors back to back", NVEC);
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Idle afterwards: the result holds and nothing pulses.
        in_valid = 1'b0;
        op       = 4'b0000;
        dones    = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("idle hold hi", hi, 32'hFFFF_FFFE);
        checkOutput("idle hold lo", lo, 32'h0000_0002);
        checkOutput("idle done count", 32'(dones), 32'd0);
        checkOutput("idle stallreq", 32'(stallreq), 32'h0);
        @(posedge clk);
        #1;

        // Held issue for 40 cycles: one done at 33, restart only at 34.
        $display("[TB] held mult issue");
        in_valid = 1'b1;
        op       = OP_MULT;
        src_a    = 32'd6;
        src_b    = 32'd7;
        dones    = 0;
        done_at  = -1;
        stall33  = 1'b1;
        stall34  = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                done_at = cyc;
            end
            if (cyc == 33) stall33 = stallreq;
            if (cyc == 34) stall34 = stallreq;
            @(posedge clk);
            #1;
        end
        checkOutput("held done count", 32'(dones), 32'd1);
        checkOutput("held done cycle", 32'(done_at), 32'd33);
        checkOutput("held stall in DONE", 32'(stall33), 32'd0);
        checkOutput("held restart stall", 32'(stall34), 32'd1);
        checkOutput("held hi", hi, 32'h0);
        checkOutput("held lo", lo, 32'd42);
        in_valid = 1'b0;
        op       = 4'b0000;
        cancel   = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("flush stallreq", 32'(stallreq), 32'h0);
        @(posedge clk);
        #1;

        // Cancel in the same cycle as a start: nothing starts.
        $display("[TB] cancel with start");
        in_valid = 1'b1;
        op       = OP_DIV;
        src_a    = 32'd50;
        src_b    = 32'd5;
        cancel   = 1'b1;
        @(negedge clk);
        checkOutput("cancel-start stallreq", 32'(stallreq), 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op       = 4'b0000;
        cancel   = 1'b0;
        dones    = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("cancel-start done count", 32'(dones), 32'd0);
        checkOutput("cancel-start lo", lo, 32'd42);
        @(posedge clk);
        #1;

        // Cancel mid-divide at cycle 10.
        $display("[TB] cancel mid divide");
        in_valid = 1'b1;
        op       = OP_DIV;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        cancel   = 1'b1;
        in_valid = 1'b0;
        op       = 4'b0000;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        checkOutput("cancel stallreq at 11", 32'(stallreq), 32'h0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("cancel done count", 32'(dones), 32'd0);
        checkOutput("cancel hi kept", hi, 32'h0);
        checkOutput("cancel lo kept", lo, 32'd42);
        @(posedge clk);
        #1;

        // Reset mid-divide at cycle 10.
        $display("[TB] reset mid divide");
        in_valid = 1'b1;
        op       = OP_DIV;
        src_a    = 32'd1000;
        src_b    = 32'd3;
        repeat (10) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 4'b0000;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset-abort stallreq", 32'(stallreq), 32'h0);
        checkOutput("reset-abort hi", hi, 32'h0);
        checkOutput("reset-abort lo", lo, 32'h0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        checkOutput("reset-abort done count", 32'(dones), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
